// File: rtl/dffrf_nrmw_if.sv
// Bus bundle for the multi-port register file: packed read and write port lanes.
// The master drives addresses, enables and write data; the slave returns registered read data.
interface dffrf_nrmw_if #(
   parameter int WSIZE = 32,
   parameter int AW    = 5,
   parameter int NR    = 2,
   parameter int NW    = 1
);
   logic [NR-1:0]       RE;
   logic [NR*AW-1:0]    RA;
   logic [NR*WSIZE-1:0] DA;
   logic [NW-1:0]       WE;
   logic [NW*AW-1:0]    RW;
   logic [NW*WSIZE-1:0] DW;

   modport master (output RE, output RA, output WE, output RW, output DW, input DA);
   modport slave  (input RE, input RA, input WE, input RW, input DW, output DA);
endinterface

// File: rtl/dffrf_nrmw.sv
// NR-read / NW-write DFF register file with registered reads, optional write-first
// bypass, highest-port-wins write priority and asynchronous clear of all state.
module dffrf_nrmw #(
   parameter int WSIZE   = 32,
   parameter int RCOUNT  = 32,
   parameter int AW      = 5,
   parameter int NR      = 2,
   parameter int NW      = 1,
   parameter int R0_ZERO = 1,
   parameter int BYPASS  = 1
) (
   input  logic         CLK,
   input  logic         RST_N,
   dffrf_nrmw_if.slave  bus
);

   logic [WSIZE-1:0] mem_q [RCOUNT];
   logic [WSIZE-1:0] mem_d [RCOUNT];
   logic [WSIZE-1:0] da_q  [NR];
   logic [WSIZE-1:0] da_d  [NR];

   logic [AW-1:0]    ra    [NR];
   logic [AW-1:0]    wa    [NW];
   logic [WSIZE-1:0] wd    [NW];
   logic [NW-1:0]    wr_eff;

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         ra[i] = bus.RA[i*AW +: AW];
      end
      for (int j = 0; j < NW; j++) begin
         wa[j] = bus.RW[j*AW +: AW];
         wd[j] = bus.DW[j*WSIZE +: WSIZE];
      end
   end

   // A write counts only if enabled, in range, and not aimed at a hardwired-zero word 0.
   always_comb begin
      wr_eff = '0;
      for (int j = 0; j < NW; j++) begin
         wr_eff[j] = bus.WE[j]
                     && (32'(wa[j]) < RCOUNT)
                     && !((R0_ZERO != 0) && (wa[j] == '0));
      end
   end

   // Ports are scanned in ascending order so the highest-numbered effective port wins.
   always_comb begin
      for (int w = 0; w < RCOUNT; w++) begin
         mem_d[w] = mem_q[w];
         for (int j = 0; j < NW; j++) begin
            if (wr_eff[j] && (wa[j] == AW'(w))) begin
               mem_d[w] = wd[j];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         da_d[i] = da_q[i];
         if (bus.RE[i]) begin
            da_d[i] = '0;
            for (int w = 0; w < RCOUNT; w++) begin
               if (ra[i] == AW'(w)) begin
                  da_d[i] = mem_q[w];
               end
            end
            if ((R0_ZERO != 0) && (ra[i] == '0)) begin
               da_d[i] = '0;
            end
            if (BYPASS != 0) begin
               for (int j = 0; j < NW; j++) begin
                  if (wr_eff[j] && (wa[j] == ra[i])) begin
                     da_d[i] = wd[j];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int w = 0; w < RCOUNT; w++) begin
            mem_q[w] <= '0;
         end
         for (int i = 0; i < NR; i++) begin
            da_q[i] <= '0;
         end
      end else begin
         for (int w = 0; w < RCOUNT; w++) begin
            mem_q[w] <= mem_d[w];
         end
         for (int i = 0; i < NR; i++) begin
            da_q[i] <= da_d[i];
         end
      end
   end

   always_comb begin
      bus.DA = '0;
      for (int i = 0; i < NR; i++) begin
         bus.DA[i*WSIZE +: WSIZE] = da_q[i];
      end
   end

endmodule

// File: doc/dffrf_nrmw.md
# dffrf_nrmw

Parametrised multi-port register file: `NR` read ports and `NW` write ports over `RCOUNT` words of `WSIZE` bits.
- Adds over the fixed 2R1W file:
  - registered reads with per-port read enable
  - optional write-to-read bypass
  - deterministic write-port priority
  - asynchronous clear of all storage
- Sits beside the CPU datapath as the general-purpose register file for multi-issue cores.
- Built from DFF storage with per-word write-enable decoding.

## Interface
Parameters:
- `WSIZE`, 32, word width in bits
- `RCOUNT`, 32, number of words; must be ≤ 2^`AW`
- `AW`, 5, address width
- `NR`, 2, read port count (≥1)
- `NW`, 1, write port count (≥1)
- `R0_ZERO`, 1, 1 = word 0 is hardwired zero and ignores writes
- `BYPASS`, 1, 1 = a same-cycle write is forwarded to a read of the same address

Ports:
- `CLK` in 1: single clock, rising-edge.
- `RST_N` in 1: reset, asynchronous and active-low. Clears all words and all read outputs.
- `RE` in `NR`: read enable per port.
- `RA` in `NR`*`AW`: read addresses; port i occupies bits [i*`AW` +: `AW`].
- `DA` out `NR`*`WSIZE`: registered read data; port i occupies bits [i*`WSIZE` +: `WSIZE`].
- `WE` in `NW`: write enable per port.
- `RW` in `NW`*`AW`: write addresses, packed the same way as `RA`.
- `DW` in `NW`*`WSIZE`: write data, packed the same way as `DA`.

## Operation
Write:
- At a rising `CLK`, write port j is effective when all of these hold:
  - `WE`[j]=1
  - `RW`[j] < `RCOUNT`
  - not (`R0_ZERO`=1 and `RW`[j]=0)
- An effective write stores `DW`[j] into word `RW`[j].
- Multiple effective writes to the same address in one cycle: the highest-numbered port wins. Losing ports have no effect.
- Writes to different addresses in the same cycle all commit.
- Out-of-range write addresses are silently dropped.

Read:
- At a rising `CLK` with `RE`[i]=1, `DA`[i] is loaded with word `RA`[i].
- With `RE`[i]=0, `DA`[i] holds its previous value.
- An out-of-range `RA`[i] loads 0.
- With `R0_ZERO`=1, `RA`[i]=0 always loads 0.
- Bypass, `BYPASS`=1: if an effective write targets `RA`[i] in the same cycle, `DA`[i] loads the winning write's `DW` (write-first).
- Bypass, `BYPASS`=0: `DA`[i] loads the pre-write stored value (read-first).
- Read ports are independent; any number of them may read the same address.

Reset:
- `RST_N`=0 asynchronously forces every word to 0 and every `DA` lane to 0, regardless of `CLK`.
- Writes and reads sampled on an edge coincident with active reset are discarded.
- Release is synchronous to the next rising `CLK`: the first operation occurs on the first edge with `RST_N`=1.

## Timing
- Write latency is 1 cycle. Data written at edge k is readable (stored path) by a read sampled at edge k+1, visible on `DA` after that edge.
- Read latency is 1 cycle: `RA` sampled at edge k gives `DA` valid after edge k.
- Bypass path: `DW` to `DA` within the same cycle, so the same-edge write/read is visible after edge k.
- The bypass path is combinational from `DW`/`RW`/`WE` to the `DA` register input. It must close timing at the target clock for `NW` ≤ 2.
- No combinational path from any input to any output; all outputs are registered.
- Reset value of every output: `DA` = 0.

## Test plan
- **Reset:** pulse `RST_N` low mid-run after writing 0xDEADBEEF to word 5. With `RST_N` still low, `DA` must read 0 immediately. After release, `RA`[0]=5, `RE`[0]=1 must give `DA`[0]=0 after one edge.
- **Basic write/read:** with `NW`=2, `NR`=2, write 0x11111111 to word 3 via port 0 and 0x22222222 to word 7 via port 1 in one cycle. Next cycle read 3 on port 0 and 7 on port 1 → `DA` lanes = 0x11111111 / 0x22222222.
- **Conflict priority:** both write ports target word 9 in the same cycle, with 0xAAAA0000 on port 0 and 0x0000BBBB on port 1. A later read of 9 must return 0x0000BBBB.
- **Bypass:**
  - `BYPASS`=1: write 0x12345678 to word 4 while reading word 4 (old value 0x0) → `DA` = 0x12345678 after that edge.
  - Rebuild with `BYPASS`=0: the same stimulus → 0x0, then 0x12345678 on the next read.
- **R0 and range:**
  - Write 0xFFFFFFFF to word 0 with `R0_ZERO`=1 → a read of 0 returns 0.
  - With `RCOUNT`=24, a write to address 30 is dropped, and a read of 30 returns 0.
- **Hold:** load `DA`[1]=0x5A5A5A5A, then drop `RE`[1] and change `RA`[1] while writing to that word. `DA`[1] must stay 0x5A5A5A5A until `RE`[1] returns high.
